// File: rtl/candy_sram_arbiter.sv
// candy_sram_arbiter: round-robin arbiter and access sequencer between the
// instruction-fetch port (m0), the load/store port (m1) and candy_sram.
// It carries one transaction at a time: it latches the winner's request,
// strobes the SRAM for a write (one cycle) or a read (until rdata_ready or
// timeout), and then answers the winner with a done pulse.
module candy_sram_arbiter #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 24,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_re,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_rdata_ready
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic                last_q,      last_d;      // master granted most recently
    logic                owner_q,     owner_d;     // master owning the access in flight
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;       // cycles already spent in RD
    logic [1:0]          gnt_q,       gnt_d;
    logic [1:0]          done_q,      done_d;
    logic [1:0]          err_q,       err_d;
    logic [DATA_W-1:0]   rdata0_q,    rdata0_d;
    logic [DATA_W-1:0]   rdata1_q,    rdata1_d;
    logic                sram_we_q,   sram_we_d;
    logic                sram_re_q,   sram_re_d;

    logic                elig0;
    logic                elig1;
    logic                win;
    logic                win_we;

    // A master whose done is showing this cycle sits out one arbitration round,
    // which lets it drop req after seeing done without being re-granted.
    assign elig0 = m0_req & ~done_q[0];
    assign elig1 = m1_req & ~done_q[1];

    // Winner selection: a sole requester wins; on a tie the one not granted last wins.
    always_comb begin
        win = elig1;
        if (elig0 && elig1) begin
            win = ~last_q;
        end
        win_we = win ? m1_we : m0_we;
    end

    // Next-state, strobe and response computation for the access sequencer.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        err_d     = 2'b00;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        sram_we_d = 1'b0;
        sram_re_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    owner_d    = win;
                    last_d     = win;
                    gnt_d[win] = 1'b1;
                    addr_d     = win ? m1_addr  : m0_addr;
                    wdata_d    = win ? m1_wdata : m0_wdata;
                    cnt_d      = '0;
                    if (win_we) begin
                        state_d   = WR;
                        sram_we_d = 1'b1;
                    end else begin
                        state_d   = RD;
                        sram_re_d = 1'b1;
                    end
                end
            end

            WR: begin
                state_d         = IDLE;
                done_d[owner_q] = 1'b1;
            end

            RD: begin
                if (sram_rdata_ready) begin
                    // Ready wins even on the timeout edge.
                    state_d         = IDLE;
                    done_d[owner_q] = 1'b1;
                    if (owner_q) begin
                        rdata1_d = sram_rdata;
                    end else begin
                        rdata0_d = sram_rdata;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d         = IDLE;
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = 1'b1;
                    if (owner_q) begin
                        rdata1_d = '0;
                    end else begin
                        rdata0_d = '0;
                    end
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    sram_re_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any access in flight silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            sram_we_q <= 1'b0;
            sram_re_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            sram_we_q <= sram_we_d;
            sram_re_q <= sram_re_d;
        end
    end

    assign m0_gnt     = gnt_q[0];
    assign m1_gnt     = gnt_q[1];
    assign m0_done    = done_q[0];
    assign m1_done    = done_q[1];
    assign m0_err     = err_q[0];
    assign m1_err     = err_q[1];
    assign m0_rdata   = rdata0_q;
    assign m1_rdata   = rdata1_q;
    assign sram_we    = sram_we_q;
    assign sram_re    = sram_re_q;
    assign sram_waddr = addr_q;
    assign sram_raddr = addr_q;
    assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_candy_sram_arbiter.sv
// Testbench for candy_sram_arbiter: directed transactions, a small SRAM
// responder, a transaction-level reference model and a per-cycle compare.
module tb_candy_sram_arbiter;

    localparam int A = 17;
    localparam int D = 24;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         m0_req, m0_we, m1_req, m1_we;
    logic [A-1:0] m0_addr, m1_addr;
    logic [D-1:0] m0_wdata, m1_wdata;
    logic         m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [D-1:0] m0_rdata, m1_rdata;
    logic         sram_we, sram_re, sram_rdata_ready;
    logic [A-1:0] sram_waddr, sram_raddr;
    logic [D-1:0] sram_wdata, sram_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    candy_sram_arbiter #(.ADDR_W(A), .DATA_W(D), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .sram_we(sram_we), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
        .sram_re(sram_re), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
        .sram_rdata_ready(sram_rdata_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- SRAM responder ----------------
    // rdly = N>0: ready rises in the N-th consecutive read-strobe cycle; 0 = never.
    logic [D-1:0] mem [16];
    int  rdly    = 1;
    int  rcnt    = 0;
    bit  resp_en = 1'b0;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
    end

    always @(negedge clk) begin
        if (resp_en) begin
            if (sram_we) mem[sram_waddr[3:0]] = sram_wdata;
            if (sram_re) begin
                rcnt++;
                sram_rdata_ready = (rdly != 0) && (rcnt >= rdly);
                sram_rdata       = mem[sram_raddr[3:0]];
            end else begin
                rcnt             = 0;
                sram_rdata_ready = 1'b0;
                sram_rdata       = '0;
            end
        end
    end

    // ---------------- Reference model ----------------
    // Tracks one transaction as (owner, kind, start edge) and predicts what the
    // outputs must show in the cycle that follows each clock edge.
    bit           busy, is_rd, own, last, e0, e1;
    int           now = 0, start = 0;
    logic [A-1:0] m_addr;
    logic [D-1:0] m_wdata;
    logic [1:0]   exp_gnt, exp_done, exp_err, prev_done;
    logic [D-1:0] exp_rd0, exp_rd1;
    bit           exp_we, exp_re;

    task automatic finish_txn(input logic [D-1:0] v, input bit err);
        if (own) exp_rd1 = v; else exp_rd0 = v;
        exp_done[own] = 1'b1;
        exp_err[own]  = err;
        busy          = 1'b0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy = 0; last = 1; exp_gnt = 0; exp_done = 0; exp_err = 0;
            exp_rd0 = 0; exp_rd1 = 0; exp_we = 0; exp_re = 0;
        end else begin
            prev_done = exp_done;
            exp_gnt = 0; exp_done = 0; exp_err = 0;
            if (!busy) begin
                e0 = m0_req && !prev_done[0];
                e1 = m1_req && !prev_done[1];
                if (e0 || e1) begin
                    own     = (e0 && e1) ? !last : e1;
                    last    = own;
                    busy    = 1;
                    start   = now;
                    is_rd   = own ? !m1_we : !m0_we;
                    m_addr  = own ? m1_addr : m0_addr;
                    m_wdata = own ? m1_wdata : m0_wdata;
                    exp_gnt[own] = 1'b1;
                end
            end else if (!is_rd) begin
                finish_txn(exp_done[0] ? exp_rd0 : (own ? exp_rd1 : exp_rd0), 1'b0);
            end else if (sram_rdata_ready) begin
                finish_txn(sram_rdata, 1'b0);
            end else if (now - start == T) begin
                finish_txn('0, 1'b1);
            end
            exp_we = busy && !is_rd;
            exp_re = busy && is_rd;
            now++;
        end
    end

    // ---------------- Per-cycle compare (posedge + 3) ----------------
    always @(posedge clk) begin
        #3;
        chk("gnt",   {m1_gnt, m0_gnt},   exp_gnt);
        chk("done",  {m1_done, m0_done}, exp_done);
        chk("err",   {m1_err, m0_err},   exp_err);
        chk("rdata0", m0_rdata, exp_rd0);
        chk("rdata1", m1_rdata, exp_rd1);
        chk("we", sram_we, exp_we);
        chk("re", sram_re, exp_re);
        if (exp_we) begin
            chk("waddr", sram_waddr, m_addr);
            chk("wdata", sram_wdata, m_wdata);
        end
        if (exp_re) chk("raddr", sram_raddr, m_addr);
        if (!rst) chk("rst_bus", {sram_waddr, sram_raddr} | sram_wdata, 0);
    end

    // ---------------- Directed stimulus ----------------
    task automatic wait_done(input bit m, output int re_n);
        re_n = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (sram_re) re_n++;
            if ((m ? m1_done : m0_done) === 1'b1) break;
        end
        chk("done_seen", m ? m1_done : m0_done, 1);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    int     re_n;
    int     gq[$];
    int     gc[$];

    initial begin
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        sram_rdata_ready = 0; sram_rdata = 0;

        // 1: random inputs under reset, outputs must all stay 0
        repeat (5) begin
            @(negedge clk);
            m0_req = 1'($urandom); m0_we = 1'($urandom); m0_addr = A'($urandom); m0_wdata = D'($urandom);
            m1_req = 1'($urandom); m1_we = 1'($urandom); m1_addr = A'($urandom); m1_wdata = D'($urandom);
            sram_rdata_ready = 1'($urandom); sram_rdata = D'($urandom);
        end
        @(negedge clk);
        chk("t1_outs", {m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, sram_we, sram_re}, 0);
        chk("t1_rdata", m0_rdata | m1_rdata, 0);
        m0_req = 0; m1_req = 0; sram_rdata_ready = 0; sram_rdata = 0; resp_en = 1;
        @(negedge clk); rst = 1'b1;

        // 2: m0 write addr 0 data 001234
        m0_we = 1; m0_addr = 17'h00000; m0_wdata = 24'h001234; m0_req = 1;
        @(negedge clk);
        chk("t2_gnt", {m1_gnt, m0_gnt}, 2'b01);
        chk("t2_we", sram_we, 1);
        chk("t2_waddr", sram_waddr, 17'h00000);
        chk("t2_wdata", sram_wdata, 24'h001234);
        @(negedge clk);
        chk("t2_we_off", sram_we, 0);
        chk("t2_done", m0_done, 1);
        chk("t2_err", m0_err, 0);
        chk("t2_re", sram_re, 0);
        m0_req = 0;

        // 3: m0 read addr 0, ready in the third RD cycle
        @(negedge clk);
        rdly = 3; m0_we = 0; m0_addr = 0; m0_req = 1;
        wait_done(0, re_n);
        m0_req = 0;
        chk("t3_re_cycles", re_n, 3);
        chk("t3_rdata", m0_rdata, 24'h001234);
        chk("t3_err", m0_err, 0);
        repeat (3) @(negedge clk);
        chk("t3_hold", m0_rdata, 24'h001234);

        // 4: both masters request continuously after reset
        do_reset();
        rdly = 1;
        m0_we = 0; m0_addr = 17'h1;
        m1_we = 1; m1_addr = 17'h2; m1_wdata = 24'hABCDEF;
        m0_req = 1; m1_req = 1;
        for (int n = 0; n < 40 && gq.size() < 4; n++) begin
            @(negedge clk);
            chk("t4_one_gnt", m0_gnt & m1_gnt, 0);
            chk("t4_one_done", m0_done & m1_done, 0);
            if (m0_gnt) begin gq.push_back(0); gc.push_back(n); end
            if (m1_gnt) begin gq.push_back(1); gc.push_back(n); end
        end
        m0_req = 0; m1_req = 0;
        chk("t4_ngrants", gq.size(), 4);
        if (gq.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t4_order", gq[i], i % 2);
            for (int i = 1; i < 4; i++) chk("t4_gap", gc[i] - gc[i-1], 2);
        end
        repeat (4) @(negedge clk);

        // 5: m1 read with data, then m1 read that times out, then m0 serviced
        m1_we = 0; m1_addr = 17'h2; m1_req = 1;
        wait_done(1, re_n);
        m1_req = 0;
        chk("t5_rdata_ok", m1_rdata, 24'hABCDEF);
        @(negedge clk);
        rdly = 0; m1_req = 1;
        wait_done(1, re_n);
        m1_req = 0;
        chk("t5_re_cycles", re_n, 16);
        chk("t5_err", m1_err, 1);
        chk("t5_rdata", m1_rdata, 0);
        @(negedge clk);
        m0_we = 1; m0_addr = 17'h5; m0_wdata = 24'h55AA55; m0_req = 1;
        wait_done(0, re_n);
        m0_req = 0;
        chk("t5_m0_err", m0_err, 0);

        // 6: reset pulse two cycles into an m0 read
        @(negedge clk);
        m0_we = 0; m0_addr = 17'h0; m0_req = 1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_re_before", sram_re, 1);
        @(posedge clk); #2;
        rst = 1'b0; m0_req = 0;
        #1;
        chk("t6_re_async", sram_re, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t6_no_done", m0_done, 0);
        end
        m0_we = 1; m0_addr = 17'h3; m0_wdata = 24'h000333;
        m1_we = 1; m1_addr = 17'h4; m1_wdata = 24'h000444;
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        chk("t6_first", {m1_gnt, m0_gnt}, 2'b01);
        wait_done(0, re_n);
        m0_req = 0;
        wait_done(1, re_n);
        m1_req = 0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/candy_sram_arbiter.md
Name: candy_sram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of candy_sram. Port 0 is instruction fetch; port 1 is load/store.
- Accepts one transaction at a time and drives the SRAM write or read strobes.
- For reads, waits for rdata_ready and returns data to the winning master with a done pulse.
- Arbitration is round-robin. A read timeout guards against a missing rdata_ready.

Parameters:
- ADDR_W, 17, SRAM address width.
- DATA_W, 24, SRAM data width.
- TIMEOUT, 16, max cycles spent in RD before aborting with error (must be at least 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  request level; transaction fields must be stable while req is high.
- m0_we, m1_we  in  1  1=write, 0=read.
- m0_addr, m1_addr  in  ADDR_W  transaction address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_gnt, m1_gnt  out  1  one-cycle pulse: request accepted and latched.
- m0_done, m1_done  out  1  one-cycle pulse: transaction complete.
- m0_err, m1_err  out  1  valid with done: read timed out.
- m0_rdata, m1_rdata  out  DATA_W  read result; valid with done, held until that master's next done.
- sram_we  out  1  SRAM write_enable.
- sram_waddr  out  ADDR_W  SRAM waddr.
- sram_wdata  out  DATA_W  SRAM wdata.
- sram_re  out  1  SRAM read_enable.
- sram_raddr  out  ADDR_W  SRAM raddr.
- sram_rdata  in  DATA_W  SRAM rdata.
- sram_rdata_ready  in  1  SRAM rdata valid.

Behaviour:
- Reset (rst=0): applies immediately and asynchronously.
  - State returns to IDLE and the timeout counter clears.
  - All outputs go to 0, including sram_we/sram_re and all rdata registers.
  - last_grant is set to 1, so m0 wins first.
  - An in-flight transaction is dropped with no done.
- States and strobes:
  - IDLE: no SRAM strobes.
  - WR: sram_we=1.
  - RD: sram_re=1.
  - SRAM address and data outputs come from latched registers and are held for the whole access.
- IDLE arbitration at each clock edge:
  - Eligible master: req=1 and its done is not high this cycle. This gives a one-cycle bubble per master, so a master can drop req after seeing done.
  - One eligible master: it wins.
  - Both eligible: the master other than last_grant wins.
  - On a win: latch we/addr/wdata, set last_grant, pulse the winner's gnt in the next cycle, and go to WR or RD.
- WR: lasts exactly one cycle.
  - On exit, done pulses in the following cycle with err=0, and state returns to IDLE.
  - Write latency from the edge that accepts req: sram_we in cycle 1, done in cycle 2.
- RD:
  - The counter starts at 0 and increments each cycle.
  - At an edge where sram_rdata_ready=1: capture sram_rdata into the winner's rdata, pulse done next cycle with err=0, go to IDLE.
  - If the counter reaches TIMEOUT-1 with no ready: capture 0 into the winner's rdata, pulse done and err, go to IDLE.
  - A ready arriving on the same edge as the timeout counts as success.
  - Minimum read latency: sram_re in cycle 1, done in cycle 2, if ready is already high.
- req dropped mid-transaction: the latched transaction still completes and done still pulses.
- Only one of sram_we/sram_re is ever high, and only in WR/RD.
- gnt and done never pulse for both masters in the same cycle.
- The SRAM sees the done-cycle IDLE as one strobe-free cycle between accesses.

Test Plan:
1. Reset: hold rst=0 with random inputs -> all outputs 0. Release rst, then assert m0_req -> m0 is granted first.
2. m0 write addr 17'h00000, data 24'h001234 -> sram_we high exactly 1 cycle with waddr 0 and wdata 001234. m0_done pulses the next cycle with m0_err=0. sram_re stays 0.
3. m0 read addr 0; SRAM model raises rdata_ready 3 cycles into RD with 24'h001234 -> sram_re held 3 cycles at raddr 0. Then m0_done=1, m0_rdata=24'h001234, and rdata holds afterwards.
4. Both masters hold req continuously after reset: m0 read addr 1, m1 write addr 2 -> grant order m0,m1,m0,m1. One-cycle IDLE between accesses. No simultaneous gnt or done.
5. m1 read with sram_rdata_ready tied 0 -> after exactly 16 RD cycles, m1_done=1, m1_err=1, m1_rdata=0. State returns to IDLE, and m0 is then serviceable.
6. rst pulsed low 2 cycles into an m0 read -> sram_re falls asynchronously. No m0_done after release, and the next request is m0-first.
